reg_bank_16: RTL and testbench
==============================

Name: reg_bank_16

Overview:
Sixteen-entry N-bit register bank with a built-in select sequencer. It sits directly upstream of the 16:1 datapath multiplexer. Its R0..R15 outputs drive the mux data inputs and its sel output drives the mux select. It gives the controller a single write port (load, increment, clear) and an automatic 0..15 sweep mode, so the mux output can be streamed one register per cycle.

Parameters:
N, 8, data width of each register and of wr_data

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
wr_en  input  1  perform op this cycle
wr_addr  input  4  target register index for op
wr_data  input  N  load value for op LOAD
op  input  2  00 LOAD, 01 INC, 10 CLR (one register), 11 CLRALL
scan_start  input  1  request a 0..15 sweep
sel_man  input  4  select value used when not scanning
R0..R15  output  N each  register contents; drive mux I0..I15
sel  output  4  mux select
sel_valid  output  1  high on each cycle that sel is part of a sweep
scan_busy  output  1  sweep in progress
scan_done  output  1  one-cycle pulse after the last sweep beat
valid  output  16  per-register written-since-clear flag

Behaviour:
- Reset (rst_n low, async): all R=0, valid=0, state IDLE, scan counter=0, sel_valid=0, scan_busy=0, scan_done=0. Reset asserted mid-sweep aborts the sweep immediately. No done pulse is produced.
- Write port is sampled on the rising clk edge when wr_en=1. Result is visible on R outputs the next cycle (1-cycle latency).
  - LOAD: R[wr_addr] <= wr_data; valid[wr_addr] <= 1.
  - INC: R[wr_addr] <= R[wr_addr]+1, modulo 2^N (all-ones wraps to 0); valid[wr_addr] <= 1.
  - CLR: R[wr_addr] <= 0; valid[wr_addr] <= 0.
  - CLRALL: every R <= 0 and valid <= 0; wr_addr and wr_data are ignored.
- wr_en=0: all registers hold.
- Only one op per cycle; there is no read-during-write hazard. R is the registered value, so the downstream mux sees the old value during the write cycle and the new value afterwards.
- Sequencer FSM has three states: IDLE, SCAN, DONE.
  - IDLE: sel=sel_man (combinational pass-through), sel_valid=0, scan_busy=0. scan_start=1 moves to SCAN with counter=0.
  - SCAN: sel=counter, sel_valid=1, scan_busy=1. Counter increments every cycle. When counter=15, the next state is DONE. A sweep is exactly 16 consecutive beats, sel 0,1,...,15.
  - DONE: scan_done=1 for exactly one cycle, scan_busy=0, sel_valid=0, sel=sel_man. Always returns to IDLE; scan_start in DONE is ignored.
  - scan_start while in SCAN is ignored; it does not restart or extend the sweep.
  - Back-to-back sweeps: minimum gap from one sweep's last beat to the next sweep's first beat is 2 cycles (DONE, then IDLE sampling scan_start).
- Writes are allowed during a sweep. A write to the register whose index equals sel on beat k lands after that beat. The old value is streamed on beat k; the new value is streamed on a later sweep.
- scan_done and sel_valid are registered state decodes and must be glitch-free. sel in IDLE/DONE is combinational from sel_man.

Test Plan:
- Reset: drive rst_n low mid-cycle with R5=0x3C loaded and a sweep at beat 7 -> immediately R5=0, valid=0x0000, scan_busy=0, sel=sel_man, and no scan_done pulse ever follows.
- Load and readback: LOAD R3=0xA5, then LOAD R15=0x5A in consecutive cycles -> R3=0xA5 one cycle after the first write, R15=0x5A one cycle after the second, valid=0x8008.
- INC wrap: LOAD R0=0xFE, then INC R0 twice -> R0 reads 0xFF, then 0x00; valid[0] stays 1.
- CLR/CLRALL: load R1=0x11 and R2=0x22; CLR R1 -> R1=0, valid=0x0004. Then CLRALL with wr_addr=1 -> all R=0, valid=0.
- Sweep: preload Ri=i*0x10 and pulse scan_start -> 16 beats with sel=0..15 and sel_valid=1, then scan_done high for one cycle on the 17th cycle, then IDLE. A second scan_start asserted at beat 5 has no effect.
- Write during sweep: LOAD R8=0x77 issued on the cycle sel=8 (old R8=0x80) -> beat 8 presents R8=0x80, R8=0x77 from the next cycle, and the sweep completes normally.

Source files
------------

// File: rtl/reg_bank_16.sv
// Sixteen-entry register bank with a single write port and a 0..15 sweep
// sequencer that drives the select of the downstream 16:1 mux.
module reg_bank_16 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [1:0]   op,
  input  logic         scan_start,
  input  logic [3:0]   sel_man,
  output logic [N-1:0] R0,
  output logic [N-1:0] R1,
  output logic [N-1:0] R2,
  output logic [N-1:0] R3,
  output logic [N-1:0] R4,
  output logic [N-1:0] R5,
  output logic [N-1:0] R6,
  output logic [N-1:0] R7,
  output logic [N-1:0] R8,
  output logic [N-1:0] R9,
  output logic [N-1:0] R10,
  output logic [N-1:0] R11,
  output logic [N-1:0] R12,
  output logic [N-1:0] R13,
  output logic [N-1:0] R14,
  output logic [N-1:0] R15,
  output logic [3:0]   sel,
  output logic         sel_valid,
  output logic         scan_busy,
  output logic         scan_done,
  output logic [15:0]  valid
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_CALL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  logic [N-1:0] r_mem [16];
  logic [15:0]  r_valid;
  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic         r_sel_valid;
  logic         r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
      r_valid <= '0;
    end else if (wr_en) begin
      unique case (op)
        OP_LOAD: begin
          r_mem[wr_addr]   <= wr_data;
          r_valid[wr_addr] <= 1'b1;
        end
        OP_INC: begin
          r_mem[wr_addr]   <= r_mem[wr_addr] + N'(1);
          r_valid[wr_addr] <= 1'b1;
        end
        OP_CLR: begin
          r_mem[wr_addr]   <= '0;
          r_valid[wr_addr] <= 1'b0;
        end
        OP_CALL: begin
          for (int i = 0; i < 16; i++) r_mem[i] <= '0;
          r_valid <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (scan_start) begin
          w_next    = SCAN;
          w_cnt_nxt = 4'd0;
        end
      end
      SCAN: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status bits come straight from flops so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_sel_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_nxt;
      r_sel_valid <= (w_next == SCAN);
      r_done      <= (w_next == DONE);
    end
  end

  assign sel       = r_sel_valid ? r_cnt : sel_man;
  assign sel_valid = r_sel_valid;
  assign scan_busy = r_sel_valid;
  assign scan_done = r_done;
  assign valid     = r_valid;

  assign R0  = r_mem[0];
  assign R1  = r_mem[1];
  assign R2  = r_mem[2];
  assign R3  = r_mem[3];
  assign R4  = r_mem[4];
  assign R5  = r_mem[5];
  assign R6  = r_mem[6];
  assign R7  = r_mem[7];
  assign R8  = r_mem[8];
  assign R9  = r_mem[9];
  assign R10 = r_mem[10];
  assign R11 = r_mem[11];
  assign R12 = r_mem[12];
  assign R13 = r_mem[13];
  assign R14 = r_mem[14];
  assign R15 = r_mem[15];

endmodule

// File: tb/tb_reg_bank_16.sv
// Bench for reg_bank_16: direct write-port checks plus a scoreboard
// that checks every sweep beat and done pulse as the DUT presents them.
module tb_reg_bank_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  op;
  logic        scan_start;
  logic [3:0]  sel_man;
  logic [7:0]  R [16];
  logic [3:0]  sel;
  logic        sel_valid;
  logic        scan_busy;
  logic        scan_done;
  logic [15:0] valid;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic prev15 = 1'b0;

  typedef struct {
    logic [3:0] s;
    logic [7:0] d;
  } beat_t;
  beat_t q[$];

  always #5 clk = ~clk;

  reg_bank_16 #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .op(op), .scan_start(scan_start),
    .sel_man(sel_man),
    .R0(R[0]), .R1(R[1]), .R2(R[2]), .R3(R[3]),
    .R4(R[4]), .R5(R[5]), .R6(R[6]), .R7(R[7]),
    .R8(R[8]), .R9(R[9]), .R10(R[10]), .R11(R[11]),
    .R12(R[12]), .R13(R[13]), .R14(R[14]), .R15(R[15]),
    .sel(sel), .sel_valid(sel_valid), .scan_busy(scan_busy),
    .scan_done(scan_done), .valid(valid)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] o, input logic [3:0] a,
                    input logic [7:0] d);
    wr_en = 1'b1; op = o; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_scan();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
  endtask

  task automatic wait_done(input int exp);
    int n = 0;
    while (done_cnt < exp && n < 40) begin
      step();
      n++;
    end
    check("done_count", done_cnt, exp);
  endtask

  // Monitor: pops one expected beat per sel_valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sel_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected: sel %0h expected no beat", sel);
        end else begin
          beat_t e;
          e = q.pop_front();
          check("beat_sel", 32'(sel), 32'(e.s));
          check("beat_data", 32'(R[sel]), 32'(e.d));
          check("beat_busy", 32'(scan_busy), 32'd1);
        end
      end
      if (scan_done) begin
        done_cnt++;
        check("done_after_beat15", 32'(prev15), 32'd1);
        check("done_busy", 32'(scan_busy), 32'd0);
      end
      prev15 = sel_valid && (sel == 4'd15);
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    op = 2'b00; scan_start = 1'b0; sel_man = 4'h9;
    #12;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_R7", 32'(R[7]), 32'h0);
    check("rst_busy", 32'(scan_busy), 32'h0);
    check("rst_sel", 32'(sel), 32'h9);
    rst_n = 1'b1;
    step();

    wr_en = 1'b1; op = 2'b00; wr_addr = 4'd3; wr_data = 8'hA5;
    step();
    check("load_R3", 32'(R[3]), 32'hA5);
    wr_addr = 4'd15; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    check("load_R15", 32'(R[15]), 32'h5A);
    check("load_valid", 32'(valid), 32'h8008);

    wr(2'b00, 4'd0, 8'hFE);
    wr(2'b01, 4'd0, 8'h00);
    check("inc_R0_ff", 32'(R[0]), 32'hFF);
    wr(2'b01, 4'd0, 8'h00);
    check("inc_R0_wrap", 32'(R[0]), 32'h00);
    check("inc_valid0", 32'(valid[0]), 32'h1);

    wr(2'b11, 4'd0, 8'h00);
    wr(2'b00, 4'd1, 8'h11);
    wr(2'b00, 4'd2, 8'h22);
    wr(2'b10, 4'd1, 8'hEE);
    check("clr_R1", 32'(R[1]), 32'h0);
    check("clr_R2", 32'(R[2]), 32'h22);
    check("clr_valid", 32'(valid), 32'h0004);
    wr(2'b11, 4'd1, 8'h99);
    check("clrall_R2", 32'(R[2]), 32'h0);
    check("clrall_valid", 32'(valid), 32'h0);

    for (int i = 0; i < 16; i++) wr(2'b00, 4'(i), 8'(i * 16));
    check("preload_valid", 32'(valid), 32'hFFFF);
    sel_man = 4'h6;
    #1;
    check("idle_sel", 32'(sel), 32'h6);
    for (int i = 0; i < 16; i++) q.push_back('{4'(i), 8'(i * 16)});
    start_scan();
    repeat (5) step();
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    wait_done(1);
    check("sweep1_queue", 32'(q.size()), 32'd0);
    step();
    check("post_done_sel", 32'(sel), 32'h6);
    check("post_done_flag", 32'(scan_done), 32'd0);
    repeat (3) step();

    for (int i = 0; i < 16; i++) q.push_back('{4'(i), 8'(i * 16)});
    start_scan();
    repeat (8) step();
    wr(2'b00, 4'd8, 8'h77);
    check("wdur_R8", 32'(R[8]), 32'h77);
    wait_done(2);
    check("sweep2_queue", 32'(q.size()), 32'd0);
    step();

    wr(2'b00, 4'd5, 8'h3C);
    for (int i = 0; i < 7; i++)
      q.push_back('{4'(i), (i == 5) ? 8'h3C : 8'(i * 16)});
    start_scan();
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_R5", 32'(R[5]), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_busy", 32'(scan_busy), 32'h0);
    check("arst_sel", 32'(sel), 32'h6);
    check("arst_queue", 32'(q.size()), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (25) step();
    check("arst_no_done", done_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
